// File: rtl/nio2_onchip_mem_arbiter_if.sv
// Avalon-MM slave-port bundle used by each master in front of the on-chip RAM arbiter.
// The master modport is the interconnect side; the slave modport is the arbiter side.
interface nio2_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nio2_onchip_mem_arbiter.sv
// Round-robin two-master arbiter in front of a single-port on-chip RAM with 1-cycle read latency.
// Grants are combinational; only the read-return owner and the fairness pointer are registered.
module nio2_onchip_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  nio2_onchip_mem_arbiter_if.slave s0,
  nio2_onchip_mem_arbiter_if.slave s1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [BE_W-1:0]       mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam logic [0:0] PORT_S0 = 1'b0;
  localparam logic [0:0] PORT_S1 = 1'b1;

  logic       req0, req1;
  logic       grant0, grant1, any_grant;
  logic       rd_accept;
  logic [0:0] last_grant;
  logic       rd_pend;
  logic [0:0] rd_owner;
  logic [BE_W-1:0] be_sel;

  assign req0 = s0.read | s0.write;
  assign req1 = s1.read | s1.write;

  // On a conflict the port that did not win last time goes first; nothing is granted in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (last_grant == PORT_S1) grant0 = 1'b1;
        else                       grant1 = 1'b1;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign any_grant = grant0 | grant1;

  assign s0.waitrequest = reset | (req0 & ~grant0);
  assign s1.waitrequest = reset | (req1 & ~grant1);

  always_comb begin
    mem_address   = s0.address;
    mem_writedata = s0.writedata;
    be_sel        = s0.byteenable;
    if (grant1) begin
      mem_address   = s1.address;
      mem_writedata = s1.writedata;
      be_sel        = s1.byteenable;
    end
  end

  // Read+write on one port counts as a write, so write wins when building the RAM command.
  assign mem_write      = (grant0 & s0.write) | (grant1 & s1.write);
  assign mem_chipselect = any_grant;
  assign mem_byteenable = mem_write ? be_sel : {BE_W{1'b1}};
  assign mem_clken      = ~reset;
  assign rd_accept      = any_grant & ~mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend    <= 1'b0;
      rd_owner   <= PORT_S0;
      last_grant <= PORT_S1;
    end else begin
      rd_pend <= rd_accept;
      if (rd_accept) rd_owner <= grant1 ? PORT_S1 : PORT_S0;
      if (any_grant) last_grant <= grant1 ? PORT_S1 : PORT_S0;
    end
  end

  assign s0.readdatavalid = ~reset & rd_pend & (rd_owner == PORT_S0);
  assign s1.readdatavalid = ~reset & rd_pend & (rd_owner == PORT_S1);
  assign s0.readdata      = mem_readdata;
  assign s1.readdata      = mem_readdata;

endmodule

// File: tb/tb_nio2_onchip_mem_arbiter.sv
// Randomized and directed bench for the on-chip RAM arbiter, with a RAM model behind it
// and a transaction-level reference model predicting grants, stalls and read returns.
module tb_nio2_onchip_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = 4;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } cmd_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;

  nio2_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m0 ();
  nio2_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m1 ();

  nio2_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .clk            (clk),
    .reset          (reset),
    .s0             (m0),
    .s1             (m1),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  // Single-port RAM with byte enables and registered read data; unwritten words read as zero.
  logic [DW-1:0] ram [int];
  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (mem_clken && mem_chipselect) begin
      w = ram.exists(int'(mem_address)) ? ram[int'(mem_address)] : '0;
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
        ram[int'(mem_address)] = w;
      end else begin
        mem_readdata <= w;
      end
    end
  end

  // Reference model state: shadow memory, who won last, and the one outstanding return.
  logic [DW-1:0] shadow [int];
  int            lastWin;
  int            expPend;
  logic [DW-1:0] expData;
  logic [DW-1:0] lastRd0, lastRd1;
  cmd_t          q0[$], q1[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            retCount, firstRet, lastRet;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] shadowRd(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
  endfunction

  function automatic cmd_t mk(input logic rd, input logic wr, input logic [AW-1:0] a,
                              input logic [BW-1:0] be, input logic [DW-1:0] d);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.be = be; c.data = d;
    return c;
  endfunction

  task automatic driveIdle();
    m0.read = 0; m0.write = 0; m0.address = '0; m0.byteenable = '0; m0.writedata = '0;
    m1.read = 0; m1.write = 0; m1.address = '0; m1.byteenable = '0; m1.writedata = '0;
  endtask

  task automatic resetChecks();
    checkOutput("rst_s0_waitrequest", 32'(m0.waitrequest), 32'd1);
    checkOutput("rst_s1_waitrequest", 32'(m1.waitrequest), 32'd1);
    checkOutput("rst_s0_rdvalid", 32'(m0.readdatavalid), 32'd0);
    checkOutput("rst_s1_rdvalid", 32'(m1.readdatavalid), 32'd0);
    checkOutput("rst_chipselect", 32'(mem_chipselect), 32'd0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst_clken", 32'(mem_clken), 32'd0);
  endtask

  // One bus cycle: present queue heads, check every prediction, then retire the granted command.
  task automatic applyStimulus();
    cmd_t c0, c1, w;
    logic req0, req1;
    int   win;
    @(negedge clk);
    c0 = (q0.size() > 0) ? q0[0] : mk(0, 0, '0, '0, '0);
    c1 = (q1.size() > 0) ? q1[0] : mk(0, 0, '0, '0, '0);
    m0.read = c0.rd; m0.write = c0.wr; m0.address = c0.addr; m0.byteenable = c0.be; m0.writedata = c0.data;
    m1.read = c1.rd; m1.write = c1.wr; m1.address = c1.addr; m1.byteenable = c1.be; m1.writedata = c1.data;
    #1;
    cyc++;
    req0 = c0.rd | c0.wr;
    req1 = c1.rd | c1.wr;
    if (req0 && req1) win = (lastWin == 0) ? 1 : 0;
    else if (req0)    win = 0;
    else if (req1)    win = 1;
    else              win = -1;

    checkOutput("s0_waitrequest", 32'(m0.waitrequest), 32'(req0 && win != 0));
    checkOutput("s1_waitrequest", 32'(m1.waitrequest), 32'(req1 && win != 1));
    checkOutput("s0_readdatavalid", 32'(m0.readdatavalid), 32'(expPend == 0));
    checkOutput("s1_readdatavalid", 32'(m1.readdatavalid), 32'(expPend == 1));
    if (expPend == 0) begin
      checkOutput("s0_readdata", m0.readdata, expData);
      lastRd0 = m0.readdata;
    end
    if (expPend == 1) begin
      checkOutput("s1_readdata", m1.readdata, expData);
      lastRd1 = m1.readdata;
    end
    if (expPend >= 0) begin
      retCount++;
      if (retCount == 1) firstRet = cyc;
      lastRet = cyc;
    end
    checkOutput("mem_chipselect", 32'(mem_chipselect), 32'(win >= 0));

    expPend = -1;
    if (win >= 0) begin
      w = (win == 1) ? c1 : c0;
      checkOutput("mem_write", 32'(mem_write), 32'(w.wr));
      checkOutput("mem_address", 32'(mem_address), 32'(w.addr));
      if (w.wr) begin
        logic [DW-1:0] v;
        v = shadowRd(w.addr);
        for (int b = 0; b < BW; b++)
          if (w.be[b]) v[8*b +: 8] = w.data[8*b +: 8];
        shadow[int'(w.addr)] = v;
      end else begin
        expPend = win;
        expData = shadowRd(w.addr);
      end
      lastWin = win;
    end
    if (q0.size() > 0 && (!req0 || win == 0)) void'(q0.pop_front());
    if (q1.size() > 0 && (!req1 || win == 1)) void'(q1.pop_front());
  endtask

  task automatic runQueues(input int maxCycles);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || expPend >= 0) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_in_budget", 32'(q0.size() + q1.size() == 0 && expPend < 0), 32'd1);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    driveIdle();
    #1;
    resetChecks();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_s0_rdvalid", 32'(m0.readdatavalid), 32'd0);
    checkOutput("post_rst_s1_rdvalid", 32'(m1.readdatavalid), 32'd0);
    checkOutput("post_rst_clken", 32'(mem_clken), 32'd1);
    expPend = -1;
    lastWin = 1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] pool [9];
    expPend = -1;
    lastWin = 1;
    lastRd0 = '0;
    lastRd1 = '0;
    reset   = 1'b1;
    driveIdle();
    m0.read  = 1'b1;
    m1.write = 1'b1;
    #2;
    resetChecks();
    @(negedge clk);
    driveIdle();
    @(negedge clk);
    reset = 1'b0;

    // Write then read back on s0.
    q0.push_back(mk(0, 1, 15'h0010, 4'hF, 32'hDEADBEEF));
    q0.push_back(mk(1, 0, 15'h0010, 4'hF, 32'h0));
    runQueues(10);
    checkOutput("wr_rd_data", lastRd0, 32'hDEADBEEF);

    // First conflict after reset goes to s0, then s1.
    q0.push_back(mk(0, 1, 15'h0001, 4'hF, 32'hAAAA0001));
    q0.push_back(mk(0, 1, 15'h0002, 4'hF, 32'hBBBB0002));
    runQueues(10);
    pulseReset();
    q0.push_back(mk(1, 0, 15'h0001, 4'h0, 32'h0));
    q1.push_back(mk(1, 0, 15'h0002, 4'h0, 32'h0));
    runQueues(10);
    checkOutput("conflict_s0_data", lastRd0, 32'hAAAA0001);
    checkOutput("conflict_s1_data", lastRd1, 32'hBBBB0002);

    // Two continuous read streams over distinct data.
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk(0, 1, 15'(16'h0100 + i), 4'hF, $urandom));
      q1.push_back(mk(0, 1, 15'(16'h0200 + i), 4'hF, $urandom));
    end
    runQueues(40);
    for (int i = 0; i < 8; i++) begin
      q0.push_back(mk(1, 0, 15'(16'h0100 + i), 4'h0, 32'h0));
      q1.push_back(mk(1, 0, 15'(16'h0200 + i), 4'h0, 32'h0));
    end
    retCount = 0;
    runQueues(40);
    checkOutput("stream_returns", 32'(retCount), 32'd16);
    checkOutput("stream_back_to_back", 32'(lastRet - firstRet), 32'd15);

    // Partial byte-enable write at the top address.
    q1.push_back(mk(0, 1, 15'h7FFF, 4'hF, 32'hFFFFFFFF));
    q1.push_back(mk(0, 1, 15'h7FFF, 4'b0101, 32'h11223344));
    q1.push_back(mk(1, 0, 15'h7FFF, 4'h0, 32'h0));
    runQueues(10);
    checkOutput("byteenable_merge", lastRd1, 32'hFF22FF44);

    // Reset during the return cycle drops the return; the next conflict goes to s0.
    q0.push_back(mk(1, 0, 15'h0010, 4'h0, 32'h0));
    applyStimulus();
    pulseReset();
    q0.push_back(mk(1, 0, 15'h0001, 4'h0, 32'h0));
    q1.push_back(mk(1, 0, 15'h0002, 4'h0, 32'h0));
    runQueues(10);

    // Read and write together behave as a write.
    q0.push_back(mk(1, 1, 15'h0020, 4'hF, 32'h00000005));
    q0.push_back(mk(1, 0, 15'h0020, 4'h0, 32'h0));
    runQueues(10);
    checkOutput("rdwr_as_write", lastRd0, 32'h00000005);

    // Random mixed traffic over a small address pool to force collisions.
    for (int i = 0; i < 8; i++) pool[i] = 15'(i);
    pool[8] = 15'h7FFF;
    for (int i = 0; i < 80; i++) begin
      q0.push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      pool[$urandom_range(0, 8)], 4'($urandom), $urandom));
      q1.push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      pool[$urandom_range(0, 8)], 4'($urandom), $urandom));
    end
    runQueues(400);

    @(negedge clk);
    driveIdle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
